// File: rtl/acq_seq_pkg.sv
// Shared state codes, stage indices and helpers for the acquisition sequencer.
// err_code reports the state in which a timeout fired, so it reuses the state codes.
package acq_seq_pkg;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_CHECK = 4'd1;
  localparam logic [3:0] ST_CONF  = 4'd2;
  localparam logic [3:0] ST_PREP  = 4'd3;
  localparam logic [3:0] ST_FITX  = 4'd4;
  localparam logic [3:0] ST_FIRX  = 4'd5;
  localparam logic [3:0] ST_CONT  = 4'd6;
  localparam logic [3:0] ST_DTRX  = 4'd7;
  localparam logic [3:0] ST_LAST  = 4'd8;
  localparam logic [3:0] ST_ERR   = 4'd9;

  localparam logic [3:0] ERR_NONE = ST_IDLE;

  typedef enum logic [3:0] {
    S_IDLE  = ST_IDLE,
    S_CHECK = ST_CHECK,
    S_CONF  = ST_CONF,
    S_PREP  = ST_PREP,
    S_FITX  = ST_FITX,
    S_FIRX  = ST_FIRX,
    S_CONT  = ST_CONT,
    S_DTRX  = ST_DTRX,
    S_LAST  = ST_LAST,
    S_ERR   = ST_ERR
  } state_t;

  localparam int STG_CHECK = 0;
  localparam int STG_CONF  = 1;
  localparam int STG_READ  = 2;
  localparam int STG_FIFO  = 3;
  localparam int STG_DTRX  = 4;
  localparam int NUM_STG   = 5;

  // A zero request still reads one channel; oversize requests saturate.
  function automatic logic [7:0] clamp_cnt(input logic [7:0] req, input logic [7:0] max_ch);
    if (req == 8'd0) return 8'd1;
    if (req > max_ch) return max_ch;
    return req;
  endfunction

endpackage

// File: rtl/acq_seq_ctrl_timeout.sv
// Per-state wait timer: clr marks the first cycle of a new state, hit fires
// when the cycles already spent in a counting state reach TIMEOUT.
module acq_timeout #(
  parameter int              TO_W    = 16,
  parameter logic [TO_W-1:0] TIMEOUT = '1
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  logic [TO_W-1:0] cnt;
  logic [TO_W-1:0] cnt_eff;

  // Clearing is folded in combinationally so the first cycle of a state reads 0.
  assign cnt_eff = clr ? '0 : cnt;
  assign hit     = en && (cnt_eff == TIMEOUT);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en && (cnt_eff != TIMEOUT)) begin
      cnt <= cnt_eff + TO_W'(1);
    end else begin
      cnt <= cnt_eff;
    end
  end

endmodule

// File: rtl/acq_seq_ctrl.sv
// Acquisition sequencer: check/configure the ADC chain, read each channel,
// drain the FIFOs and hand the frame to the Ethernet transmit path.
//
// state | meaning
// IDLE  | waiting for start
// CHECK | front-end check running (fs_check)
// CONF  | front-end configuration running (fs_conf)
// PREP  | waiting for all FIFOs to have room
// FITX  | channel read into FIFO (fs_read)
// FIRX  | FIFO drain (fs_fifo)
// CONT  | advance channel or finish the frame
// DTRX  | frame transmit (fs_dtrx)
// LAST  | frame boundary: loop, next channel, or end of run
// ERR   | a wait state timed out; err_code holds the culprit
import acq_seq_pkg::*;

module acq_seq_ctrl #(
  parameter int              NUM_ADC = 4,
  parameter int              TO_W    = 16,
  parameter logic [TO_W-1:0] TIMEOUT = 16'hFFFF
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        mode_cont,
  input  logic [7:0]  adc_cnt,
  input  logic [2:0]  fifo_full,
  output logic        fs_check,
  output logic        fs_conf,
  output logic        fs_read,
  output logic        fs_fifo,
  output logic        fs_dtrx,
  input  logic        fd_check,
  input  logic        fd_conf,
  input  logic        fd_read,
  input  logic        fd_fifo,
  input  logic        fd_dtrx,
  output logic [7:0]  adc_num,
  output logic [15:0] frame_cnt,
  output logic        busy,
  output logic        err,
  output logic [3:0]  err_code,
  output logic [3:0]  state_o
);

  localparam logic [7:0] MAX_CH = 8'(NUM_ADC);

  state_t     state;
  state_t     st_prev;
  logic       mode_q;
  logic [7:0] cnt_q;
  logic       stop_pend;
  logic       frame_done;
  logic       to_en;
  logic       to_hit;

  assign to_en = state inside {S_CHECK, S_CONF, S_PREP, S_FITX, S_FIRX, S_DTRX};

  acq_timeout #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .sys_clk (sys_clk),
    .rst     (rst),
    .clr     (state != st_prev),
    .en      (to_en),
    .hit     (to_hit)
  );

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      st_prev    <= S_IDLE;
      mode_q     <= 1'b0;
      cnt_q      <= 8'd1;
      stop_pend  <= 1'b0;
      frame_done <= 1'b0;
      adc_num    <= '0;
      frame_cnt  <= '0;
      err_code   <= ERR_NONE;
    end else begin
      st_prev <= state;
      if (stop && busy) stop_pend <= 1'b1;

      // In every wait state a done strobe is tested before the timeout, so a
      // done arriving on the timeout edge still advances the sequence.
      case (state)
        S_IDLE: if (start) begin
          mode_q     <= mode_cont;
          cnt_q      <= clamp_cnt(adc_cnt, MAX_CH);
          frame_cnt  <= '0;
          adc_num    <= '0;
          stop_pend  <= 1'b0;
          frame_done <= 1'b0;
          err_code   <= ERR_NONE;
          state      <= S_CHECK;
        end
        S_CHECK: if (fd_check) state <= S_CONF;
          else if (to_hit) begin state <= S_ERR; err_code <= state; adc_num <= '0; end
        S_CONF: if (fd_conf) state <= S_PREP;
          else if (to_hit) begin state <= S_ERR; err_code <= state; adc_num <= '0; end
        S_PREP: if (fifo_full == 3'b000) state <= S_FITX;
          else if (to_hit) begin state <= S_ERR; err_code <= state; adc_num <= '0; end
        S_FITX: if (fd_read) state <= S_FIRX;
          else if (to_hit) begin state <= S_ERR; err_code <= state; adc_num <= '0; end
        S_FIRX: if (fd_fifo) state <= S_CONT;
          else if (to_hit) begin state <= S_ERR; err_code <= state; adc_num <= '0; end
        S_CONT: if (adc_num < cnt_q - 8'd1) begin
          adc_num <= adc_num + 8'd1;
          state   <= S_LAST;
        end else begin
          state <= S_DTRX;
        end
        S_DTRX: if (fd_dtrx) begin
          adc_num    <= '0;
          frame_cnt  <= frame_cnt + 16'd1;
          frame_done <= 1'b1;
          state      <= S_LAST;
        end else if (to_hit) begin
          state <= S_ERR; err_code <= state; adc_num <= '0;
        end
        S_LAST: begin
          frame_done <= 1'b0;
          if (frame_done && (!mode_q || stop_pend)) state <= S_IDLE;
          else state <= S_PREP;
        end
        S_ERR: if (start) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign fs_check = (state == S_CHECK);
  assign fs_conf  = (state == S_CONF);
  assign fs_read  = (state == S_FITX);
  assign fs_fifo  = (state == S_FIRX);
  assign fs_dtrx  = (state == S_DTRX);
  assign busy     = (state != S_IDLE) && (state != S_ERR);
  assign err      = (state == S_ERR);
  assign state_o  = state;

endmodule

// File: tb/tb_acq_seq_ctrl.sv
// Bench for acq_seq_ctrl: an fd responder, a state monitor and a run-level
// model predicting channel order, frame count and total busy cycles.
import acq_seq_pkg::*;

module tb_acq_seq_ctrl;

  localparam int NADC = 4;
  localparam int TOUT = 20;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        mode_cont = 1'b0;
  logic [7:0]  adc_cnt = 8'd0;
  logic [2:0]  fifo_full = 3'b000;
  logic        fs_check, fs_conf, fs_read, fs_fifo, fs_dtrx;
  logic        fd_check, fd_conf, fd_read, fd_fifo, fd_dtrx;
  logic [7:0]  adc_num;
  logic [15:0] frame_cnt;
  logic        busy, err;
  logic [3:0]  err_code, state_o;

  acq_seq_ctrl #(.NUM_ADC(NADC), .TO_W(16), .TIMEOUT(16'(TOUT))) dut (
    .sys_clk(sys_clk), .rst(rst), .start(start), .stop(stop),
    .mode_cont(mode_cont), .adc_cnt(adc_cnt), .fifo_full(fifo_full),
    .fs_check(fs_check), .fs_conf(fs_conf), .fs_read(fs_read),
    .fs_fifo(fs_fifo), .fs_dtrx(fs_dtrx),
    .fd_check(fd_check), .fd_conf(fd_conf), .fd_read(fd_read),
    .fd_fifo(fd_fifo), .fd_dtrx(fd_dtrx),
    .adc_num(adc_num), .frame_cnt(frame_cnt), .busy(busy), .err(err),
    .err_code(err_code), .state_o(state_o)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // fd responder: raises fd_X resp_dly cycles into each fs_X window.
  logic [4:0] fs_v;
  logic [4:0] fd_v = '0;
  logic [4:0] resp_en = 5'b11111;
  int         resp_dly = 0;
  int         age [5];
  assign fs_v = {fs_dtrx, fs_fifo, fs_read, fs_conf, fs_check};
  assign fd_check = fd_v[STG_CHECK];
  assign fd_conf  = fd_v[STG_CONF];
  assign fd_read  = fd_v[STG_READ];
  assign fd_fifo  = fd_v[STG_FIFO];
  assign fd_dtrx  = fd_v[STG_DTRX];

  always @(negedge sys_clk) begin
    for (int s = 0; s < NUM_STG; s++) begin
      if (fs_v[s] && resp_en[s]) begin
        age[s]++;
        fd_v[s] = (age[s] > resp_dly);
      end else begin
        age[s]  = 0;
        fd_v[s] = 1'b0;
      end
    end
  end

  // Monitor: output decode per cycle, FITX entries and DTRX entries.
  logic [7:0] fitx_q[$];
  int         dtrx_n = 0;
  logic [3:0] mon_prev = ST_IDLE;

  always @(negedge sys_clk) begin
    if (!rst) begin
      chk("decode", 32'({fs_check, fs_conf, fs_read, fs_fifo, fs_dtrx, busy, err}),
          32'({state_o == ST_CHECK, state_o == ST_CONF, state_o == ST_FITX,
               state_o == ST_FIRX, state_o == ST_DTRX,
               state_o != ST_IDLE && state_o != ST_ERR, state_o == ST_ERR}));
      if (state_o == ST_FITX && mon_prev != ST_FITX) fitx_q.push_back(adc_num);
      if (state_o == ST_DTRX && mon_prev != ST_DTRX) dtrx_n++;
    end
    mon_prev = state_o;
  end

  task automatic pulse_start(input bit m, input logic [7:0] c);
    fitx_q.delete();
    dtrx_n    = 0;
    mode_cont = m;
    adc_cnt   = c;
    start     = 1'b1;
    @(negedge sys_clk);
    start     = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] s, input string tag);
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (state_o == s) begin ok = 1; break; end
      @(negedge sys_clk);
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  // One complete run checked against the run-level model.
  task automatic run(input bit m, input logic [7:0] c, input int d, input int sf,
                     input bit xs, input string tag);
    int  n, f, exp_cyc, cyc;
    bit  done, stop_sent;
    n = (c == 8'd0) ? 1 : (int'(c) > NADC ? NADC : int'(c));
    f = m ? sf : 1;
    exp_cyc = 2 * (d + 1) + f * (n * (2 * d + 5) + d + 1);
    resp_dly = d;
    pulse_start(m, c);
    cyc = 0; done = 0; stop_sent = 0;
    for (int i = 0; i < 5000; i++) begin
      stop  = 1'b0;
      start = 1'b0;
      if (!busy) begin done = 1; break; end
      cyc++;
      if (m && !stop_sent && int'(frame_cnt) == sf - 1 && state_o == ST_FIRX) begin
        stop = 1'b1;
        stop_sent = 1;
      end
      if (xs && cyc == 5) begin
        start   = 1'b1;
        adc_cnt = 8'($urandom_range(0, 255));
      end
      @(negedge sys_clk);
    end
    stop  = 1'b0;
    start = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_fitx_n"}, 32'(fitx_q.size()), 32'(n * f));
    for (int i = 0; i < fitx_q.size() && i < n * f; i++)
      chk({tag, "_fitx_ch"}, 32'(fitx_q[i]), 32'(i % n));
    chk({tag, "_dtrx_n"}, 32'(dtrx_n), 32'(f));
    chk({tag, "_frames"}, 32'(frame_cnt), 32'(f));
    chk({tag, "_idle"}, 32'(state_o), 32'(ST_IDLE));
    chk({tag, "_adc_num"}, 32'(adc_num), 32'd0);
    @(negedge sys_clk);
  endtask

  initial begin
    int k;
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    @(negedge sys_clk);

    chk("rst_state", 32'(state_o), 32'(ST_IDLE));
    chk("rst_outs", 32'({busy, err, fs_check, fs_conf, fs_read, fs_fifo, fs_dtrx}), 32'd0);
    chk("rst_adc_num", 32'(adc_num), 32'd0);
    chk("rst_frames", 32'(frame_cnt), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);

    run(1'b0, 8'd3, 2, 1, 1'b0, "single3");
    run(1'b1, 8'd2, 1, 3, 1'b0, "cont_stop3");
    run(1'b0, 8'd0, 0, 1, 1'b0, "cnt0");
    run(1'b0, 8'd200, 0, 1, 1'b0, "cnt200");
    run(1'b0, 8'd2, TOUT, 1, 1'b0, "fd_on_timeout");

    // FIFO full holds PREP; FITX follows the cycle after it clears.
    resp_dly  = 0;
    fifo_full = 3'b100;
    pulse_start(1'b0, 8'd1);
    wait_state(ST_PREP, "fifo_reach_prep");
    repeat (10) @(negedge sys_clk);
    chk("fifo_hold_prep", 32'(state_o), 32'(ST_PREP));
    fifo_full = 3'b000;
    @(negedge sys_clk);
    chk("fifo_then_fitx", 32'(state_o), 32'(ST_FITX));
    wait_state(ST_IDLE, "fifo_back_idle");
    chk("fifo_frames", 32'(frame_cnt), 32'd1);

    // fd_conf withheld: ERR TIMEOUT+1 cycles after CONF entry.
    resp_en = 5'b11111 & ~(5'b1 << STG_CONF);
    pulse_start(1'b0, 8'd2);
    wait_state(ST_CONF, "to_reach_conf");
    k = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      k++;
      if (state_o == ST_ERR) break;
    end
    chk("to_cycles", 32'(k), 32'(TOUT + 1));
    chk("to_err_code", 32'(err_code), 32'(ST_CONF));
    chk("to_err_flag", 32'({err, busy}), 32'b10);
    chk("to_fs_all", 32'({fs_check, fs_conf, fs_read, fs_fifo, fs_dtrx}), 32'd0);
    resp_en = 5'b11111;
    stop = 1'b1;
    @(negedge sys_clk);
    stop = 1'b0;
    chk("to_stop_ignored", 32'(state_o), 32'(ST_ERR));
    pulse_start(1'b0, 8'd1);
    chk("to_start_idle", 32'(state_o), 32'(ST_IDLE));
    chk("to_err_clear", 32'(err), 32'd0);

    // Asynchronous reset during DTRX of frame 2.
    resp_dly = 1;
    pulse_start(1'b1, 8'd3);
    k = 0;
    for (int i = 0; i < 2000; i++) begin
      if (frame_cnt == 16'd1 && state_o == ST_DTRX) begin k = 1; break; end
      @(negedge sys_clk);
    end
    chk("rstmid_reach", 32'(k), 32'd1);
    chk("rstmid_pre_adc", 32'(adc_num), 32'd2);
    rst = 1'b1;
    #1;
    chk("rstmid_state", 32'(state_o), 32'(ST_IDLE));
    chk("rstmid_adc_num", 32'(adc_num), 32'd0);
    chk("rstmid_frames", 32'(frame_cnt), 32'd0);
    chk("rstmid_fs_dtrx", 32'(fs_dtrx), 32'd0);
    @(negedge sys_clk);
    rst = 1'b0;
    @(negedge sys_clk);

    for (int r = 0; r < 8; r++) begin
      run(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
          int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: bench still running at %0t", $time);
    $fatal(1);
  end

endmodule
